// File: rtl/sram_burst_ctrl_if.sv
// rtl/sram_burst_ctrl_if.sv - 68030 local bus and SRAM control signal bundle for sram_burst_ctrl
interface sram_burst_ctrl_if #(
    parameter int BANKS = 2
);
    logic [31:0]        A;
    logic [1:0]         SIZ;
    logic               AS20;
    logic               DS20;
    logic               RW20;
    logic               DECODE;
    logic               CBREQ;
    logic               CBACK;
    logic               STERM;
    logic               CIIN;
    logic               INTCYCLE;
    logic [1:0]         RAMA;
    logic [4*BANKS-1:0] RAMCS;
    logic               RAMOE;
    logic               RAMWE;

    modport master (
        output A, SIZ, AS20, DS20, RW20, DECODE, CBREQ,
        input  CBACK, STERM, CIIN, INTCYCLE, RAMA, RAMCS, RAMOE, RAMWE
    );

    modport slave (
        input  A, SIZ, AS20, DS20, RW20, DECODE, CBREQ,
        output CBACK, STERM, CIIN, INTCYCLE, RAMA, RAMCS, RAMOE, RAMWE
    );
endinterface

// File: rtl/sram_burst_ctrl.sv
// rtl/sram_burst_ctrl.sv - 68030 fast-RAM controller: byte lanes, bank selects, wait states, cache line bursts
module sram_burst_ctrl #(
    parameter int BANKS       = 2,
    parameter int BANK_LSB    = 21,
    parameter int WAIT_STATES = 1,
    parameter int BURST_EN    = 1,
    parameter int CACHEABLE   = 1
) (
    input  logic             CLKCPU,
    input  logic             RESET,
    sram_burst_ctrl_if.slave bus
);

    localparam int         BW = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam logic [2:0] WS = 3'(WAIT_STATES);

    typedef enum logic [2:0] {IDLE, WAIT, TERM, BURST, DONE} state_t;

    state_t             state;
    logic [2:0]         wait_cnt;
    logic [1:0]         beat;
    logic               burst;
    logic               rd;

    logic [BW-1:0]      bank_idx;
    logic               bank_ok;
    logic [2:0]         lane_first;
    logic [2:0]         lane_last;
    logic [2:0]         lane_span;
    logic [3:0]         lane_mask;
    logic [4*BANKS-1:0] cs_sel;
    logic               unused_addr;

    assign unused_addr = ^bus.A;

    always_comb begin
        bank_idx = '0;
        if (BANKS > 1) bank_idx = bus.A[BANK_LSB +: BW];
    end

    assign bank_ok = int'({1'b0, bank_idx}) < BANKS;

    // Reads drive the whole 32-bit bus; writes enable only the addressed lanes, clipped at lane 3.
    always_comb begin
        lane_first = {1'b0, bus.A[1:0]};
        case (bus.SIZ)
            2'b01:   lane_span = 3'd1;
            2'b10:   lane_span = 3'd2;
            2'b11:   lane_span = 3'd3;
            default: lane_span = 3'd4;
        endcase
        lane_last = lane_first + lane_span - 3'd1;
        for (int i = 0; i < 4; i++) begin
            lane_mask[i] = bus.RW20 | ((3'(i) >= lane_first) && (3'(i) <= lane_last));
        end
        cs_sel = '1;
        if (bank_ok) cs_sel[4*bank_idx +: 4] = ~lane_mask;
    end

    // STERM is low exactly while the FSM sits in TERM; back-to-back TERMs give zero-wait bursts.
    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            beat         <= '0;
            burst        <= 1'b0;
            rd           <= 1'b1;
            bus.STERM    <= 1'b1;
            bus.CBACK    <= 1'b1;
            bus.CIIN     <= 1'b1;
            bus.INTCYCLE <= 1'b1;
            bus.RAMCS    <= '1;
            bus.RAMOE    <= 1'b1;
            bus.RAMWE    <= 1'b1;
            bus.RAMA     <= '0;
        end else if (state != IDLE && bus.AS20) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            beat         <= '0;
            burst        <= 1'b0;
            rd           <= 1'b1;
            bus.STERM    <= 1'b1;
            bus.CBACK    <= 1'b1;
            bus.CIIN     <= 1'b1;
            bus.INTCYCLE <= 1'b1;
            bus.RAMCS    <= '1;
            bus.RAMOE    <= 1'b1;
            bus.RAMWE    <= 1'b1;
            bus.RAMA     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.AS20 && !bus.DECODE && bank_ok) begin
                        rd           <= bus.RW20;
                        burst        <= (BURST_EN != 0) && bus.RW20 && !bus.CBREQ;
                        beat         <= '0;
                        wait_cnt     <= WS;
                        bus.RAMA     <= bus.A[3:2];
                        bus.RAMCS    <= cs_sel;
                        bus.RAMOE    <= ~bus.RW20;
                        bus.RAMWE    <= bus.RW20 | bus.DS20;
                        bus.INTCYCLE <= 1'b0;
                        bus.CIIN     <= (CACHEABLE != 0);
                        state        <= WAIT;
                    end
                end
                WAIT, BURST: begin
                    bus.RAMWE <= rd | bus.DS20;
                    if (wait_cnt == 3'd0) begin
                        state     <= TERM;
                        bus.STERM <= 1'b0;
                        bus.CBACK <= !(burst && beat != 2'd3);
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                TERM: begin
                    if (burst && beat != 2'd3) begin
                        beat      <= beat + 2'd1;
                        bus.RAMA  <= bus.RAMA + 2'd1;
                        bus.CBACK <= (beat == 2'd2);
                        if (WS != 3'd0) begin
                            bus.STERM <= 1'b1;
                            wait_cnt  <= WS - 3'd1;
                            state     <= BURST;
                        end
                    end else begin
                        bus.STERM <= 1'b1;
                        bus.CBACK <= 1'b1;
                        bus.RAMCS <= '1;
                        bus.RAMOE <= 1'b1;
                        bus.RAMWE <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// tb/tb_sram_burst_ctrl.sv - scoreboard bench for sram_burst_ctrl at 0, 1 and 3 wait states
module tb_sram_burst_ctrl;

    localparam int NB = 3;

    typedef struct packed {
        logic        sterm;
        logic        cback;
        logic        ciin;
        logic        intcycle;
        logic [1:0]  rama;
        logic [11:0] ramcs;
        logic        ramoe;
        logic        ramwe;
    } outs_t;

    typedef struct {
        int    cyc;
        outs_t o;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a;
    logic [1:0]  siz;
    logic        as_n, ds_n, rw, dec_n, cbreq_n;

    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    outs_t obs [3];
    beat_t exp_q [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_burst_ctrl_if #(.BANKS(NB)) bus0 ();
    sram_burst_ctrl_if #(.BANKS(NB)) bus1 ();
    sram_burst_ctrl_if #(.BANKS(NB)) bus3 ();

    assign {bus0.A, bus0.SIZ, bus0.AS20, bus0.DS20, bus0.RW20, bus0.DECODE, bus0.CBREQ} = {a, siz, as_n, ds_n, rw, dec_n, cbreq_n};
    assign {bus1.A, bus1.SIZ, bus1.AS20, bus1.DS20, bus1.RW20, bus1.DECODE, bus1.CBREQ} = {a, siz, as_n, ds_n, rw, dec_n, cbreq_n};
    assign {bus3.A, bus3.SIZ, bus3.AS20, bus3.DS20, bus3.RW20, bus3.DECODE, bus3.CBREQ} = {a, siz, as_n, ds_n, rw, dec_n, cbreq_n};

    assign obs[0] = {bus0.STERM, bus0.CBACK, bus0.CIIN, bus0.INTCYCLE, bus0.RAMA, bus0.RAMCS, bus0.RAMOE, bus0.RAMWE};
    assign obs[1] = {bus1.STERM, bus1.CBACK, bus1.CIIN, bus1.INTCYCLE, bus1.RAMA, bus1.RAMCS, bus1.RAMOE, bus1.RAMWE};
    assign obs[2] = {bus3.STERM, bus3.CBACK, bus3.CIIN, bus3.INTCYCLE, bus3.RAMA, bus3.RAMCS, bus3.RAMOE, bus3.RAMWE};

    sram_burst_ctrl #(.BANKS(NB), .BANK_LSB(21), .WAIT_STATES(0), .BURST_EN(1), .CACHEABLE(1))
        u_ws0 (.CLKCPU(clk), .RESET(rst_n), .bus(bus0));
    sram_burst_ctrl #(.BANKS(NB), .BANK_LSB(21), .WAIT_STATES(1), .BURST_EN(1), .CACHEABLE(1))
        u_ws1 (.CLKCPU(clk), .RESET(rst_n), .bus(bus1));
    sram_burst_ctrl #(.BANKS(NB), .BANK_LSB(21), .WAIT_STATES(3), .BURST_EN(1), .CACHEABLE(1))
        u_ws3 (.CLKCPU(clk), .RESET(rst_n), .bus(bus3));

    function automatic int ws_of(int d);
        return (d == 0) ? 0 : (d == 1) ? 1 : 3;
    endfunction

    function automatic outs_t mk(logic sterm, logic cback, logic intcycle, logic [1:0] rama,
                                 logic [11:0] cs, logic oe, logic we);
        outs_t o;
        o.sterm = sterm; o.cback = cback; o.ciin = 1'b1; o.intcycle = intcycle;
        o.rama = rama; o.ramcs = cs; o.ramoe = oe; o.ramwe = we;
        return o;
    endfunction

    // Lanes are the bytes the CPU addresses: offsets a10 .. a10+size-1 that fall inside the longword.
    function automatic logic [11:0] exp_cs(int bank, bit rd, logic [1:0] a10, logic [1:0] sz);
        logic [11:0] cs;
        int n;
        cs = '1;
        n  = (sz == 2'b00) ? 4 : int'(sz);
        for (int lane = 0; lane < 4; lane++)
            if (rd || (lane >= int'(a10) && lane < int'(a10) + n)) cs[bank*4 + lane] = 1'b0;
        return cs;
    endfunction

    task automatic check(string name, int d, logic [31:0] act, logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc %0d: got %h want %h", name, d, cyc, act, want);
        end
    endtask

    always @(negedge clk) begin : monitor
        beat_t b;
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                if (obs[d].sterm === 1'b0) begin
                    if (exp_q[d].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_sterm dut%0d cyc %0d: got STERM=0 want 1", d, cyc);
                    end else begin
                        b = exp_q[d].pop_front();
                        check("beat_cycle", d, cyc, b.cyc);
                        check("beat_outputs", d, {12'b0, obs[d]}, {12'b0, b.o});
                    end
                end
            end
        end
    end

    // One bus cycle: AS20/DS20 held low for h sampling edges, then released (or RESET pulsed).
    task automatic run_txn(logic [31:0] addr, logic [1:0] sz, bit rd, bit cbr_n, bit dn,
                           int h, bit use_reset);
        int    n, bank, beats, c;
        bit    acc;
        outs_t o;
        beat_t b;
        logic [11:0] cs;
        @(negedge clk);
        n     = cyc + 1;
        bank  = int'(addr[22:21]);
        acc   = !dn && bank < NB;
        beats = (rd && !cbr_n) ? 4 : 1;
        cs    = acc ? exp_cs(bank, rd, addr[1:0], sz) : 12'hFFF;
        if (acc) begin
            for (int d = 0; d < 3; d++) begin
                for (int k = 0; k < beats; k++) begin
                    c = n + (ws_of(d) + 1) * (k + 1);
                    if (c <= n + h - 1) begin
                        b.cyc = c;
                        b.o   = mk(1'b0, (beats == 4) ? (k == 3) : 1'b1, 1'b0,
                                   2'(int'(addr[3:2]) + k), cs, !rd, rd);
                        exp_q[d].push_back(b);
                    end
                end
            end
        end
        a = addr; siz = sz; rw = rd; cbreq_n = cbr_n; dec_n = dn; as_n = 1'b0; ds_n = 1'b0;
        @(negedge clk);
        o = acc ? mk(1'b1, 1'b1, 1'b0, addr[3:2], cs, !rd, rd) : mk(1'b1, 1'b1, 1'b1, 2'b00, 12'hFFF, 1'b1, 1'b1);
        for (int d = 0; d < 3; d++) check("after_e0", d, {12'b0, obs[d]}, {12'b0, o});
        repeat (h - 1) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            if (acc && (ws_of(d) + 1) * beats < h - 1) begin
                o = obs[d];
                o.rama = 2'b00;
                check("done_inactive", d, {12'b0, o}, {12'b0, mk(1'b1, 1'b1, 1'b0, 2'b00, 12'hFFF, 1'b1, 1'b1)});
            end
        end
        if (use_reset) begin
            #2 rst_n = 1'b0;
            #1;
            for (int d = 0; d < 3; d++)
                check("async_reset", d, {12'b0, obs[d]}, {12'b0, mk(1'b1, 1'b1, 1'b1, 2'b00, 12'hFFF, 1'b1, 1'b1)});
            as_n = 1'b1; ds_n = 1'b1;
            @(negedge clk);
            #2 rst_n = 1'b1;
        end else begin
            as_n = 1'b1; ds_n = 1'b1;
            @(negedge clk);
            for (int d = 0; d < 3; d++)
                check("after_release", d, {12'b0, obs[d]}, {12'b0, mk(1'b1, 1'b1, 1'b1, 2'b00, 12'hFFF, 1'b1, 1'b1)});
        end
        cbreq_n = 1'b1; dec_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        a = '0; siz = 2'b00; as_n = 1'b1; ds_n = 1'b1; rw = 1'b1; dec_n = 1'b1; cbreq_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++)
            check("reset_values", d, {12'b0, obs[d]}, {12'b0, mk(1'b1, 1'b1, 1'b1, 2'b00, 12'hFFF, 1'b1, 1'b1)});
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(32'h0020_0008, 2'b00, 1'b1, 1'b1, 1'b0, 20, 1'b0);   // single long read, bank 1
        run_txn(32'h0000_0008, 2'b00, 1'b1, 1'b0, 1'b0, 20, 1'b0);   // burst read from RAMA=2
        run_txn(32'h0040_0003, 2'b01, 1'b0, 1'b0, 1'b0, 20, 1'b0);   // byte write lane 3, CBREQ ignored
        run_txn(32'h0020_0003, 2'b10, 1'b0, 1'b1, 1'b0, 20, 1'b0);   // word write clipped to lane 3
        run_txn(32'h0000_0001, 2'b11, 1'b0, 1'b1, 1'b0, 20, 1'b0);   // 3-byte write lanes 1-3
        run_txn(32'h0020_0004, 2'b00, 1'b1, 1'b1, 1'b0, 3, 1'b0);    // AS20 released during wait states
        run_txn(32'h0060_0000, 2'b00, 1'b1, 1'b1, 1'b0, 20, 1'b0);   // bank 3 does not exist
        run_txn(32'h0000_0000, 2'b00, 1'b1, 1'b1, 1'b1, 20, 1'b0);   // outside RAM window
        run_txn(32'h0000_000C, 2'b00, 1'b1, 1'b0, 1'b0, 3, 1'b1);    // RESET during burst beat 2
        run_txn(32'h0040_0004, 2'b00, 1'b1, 1'b0, 1'b0, 20, 1'b0);   // burst after reset, bank 2

        for (int t = 0; t < 40; t++) begin
            run_txn($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 19)) : 20, 1'b0);
        end

        repeat (5) @(negedge clk);
        for (int d = 0; d < 3; d++) check("missing_sterm", d, exp_q[d].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
